kernal_ctrl_2by2: RTL
=====================

# kernal_ctrl_2by2

Sequencer for the 2x2 weight-stationary kernel (`kernal_2by2`). It accepts a job descriptor (four weights plus a sample count) and streams input row pairs into the kernel through valid/ready. It gates the kernel `en` so the pipeline advances only on real work, and tags in-flight samples. It returns exactly one result beat per accepted sample, with backpressure and a last marker.

## Interface
Parameters:
- dataSize, 8, element width; matches kernel.
- LEN_W, 8, width of sample count.
- LAT, 2, kernel latency in enabled cycles from input applied to result valid; ≥1.

Ports (reset is synchronous and active-high; single clock):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  descriptor accepted when high with cfg_valid.
- cfg_w  in  4*dataSize  {w4,w3,w2,w1}, w1 in LSBs.
- cfg_len  in  LEN_W  number of samples in job.
- in_valid  in  1  input pair valid.
- in_ready  out  1  input pair accepted when high with in_valid.
- in_row1, in_row2  in  dataSize each  input pair.
- k_en, k_rst  out  1 each  kernel enable / kernel reset.
- k_in_row1, k_in_row2  out  dataSize each  kernel inputs.
- k_w1..k_w4  out  dataSize each  held weights.
- k_result  in  2*dataSize+5  kernel result.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  2*dataSize+5  result, passthrough of k_result.
- out_last  out  1  final beat of job.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch weights and len, zero counters.
  - len=0: pulse done next cycle, stay IDLE, no output beats.
  - Otherwise go to CLEAR.
- CLEAR: k_rst=1 for exactly one cycle; then RUN.
- k_rst = rst | (state==CLEAR).
- Tag shift register tag[LAT-1:0] advances only when k_en=1.
  - Pushes 1 on an input fire, 0 on a drain step.
- out_valid = tag[LAT-1] & ~taken.
  - `taken` sets on out_fire and clears on any k_en.
- stall = tag[LAT-1] & ~taken & ~out_ready.
- RUN:
  - in_ready = ~stall & (issued<len).
  - in_fire drives k_en=1, k_in_row* = in_row*, issued++.
  - No input means k_en=0; the pipeline is frozen and k_result is held.
  - When issued reaches len, go to DRAIN.
- DRAIN:
  - in_ready=0, k_in_row*=0.
  - k_en=1 whenever ~stall and any tag bit or pending beat remains.
  - When tags are all zero and no beat is pending, pulse done and return to IDLE.
- out_last = out_valid & (retired==len-1). retired increments on out_fire.
- cfg_ready=0 whenever busy.
- k_w* are held from latch until the next cfg accept.
- Reset values: all outputs 0, state IDLE, weights 0, tags 0. cfg_ready=1 after reset.

## Timing
- Input fire at edge n: tag enters tag[0]. Its result is presented after LAT total enabled edges, including edge n.
- With gap-free input and out_ready=1: first out_valid LAT cycles after first in_fire, then one beat per cycle.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and k_en=0; out_data is held stable.
- Simultaneous out_fire and in_fire in the same cycle are legal and give full throughput.
- rst mid-job: next cycle is IDLE, tags cleared, no further out_valid, no done pulse.
- Job boundary:
  - The done cycle is the last busy=1 cycle.
  - cfg_ready rises the following cycle.
  - Minimum job-to-job gap is 2 cycles (done, IDLE accept, CLEAR).

## Structure
- Shared package kernal_pkg: state enum (IDLE/CLEAR/RUN/DRAIN) and the result-width constant 2*dataSize+5.
- One natural sub-module, `valid_tag_pipe`: a LAT-deep enable-gated tag shift register with occupancy flag.
- The controller instantiates it. The kernel itself is instantiated by the parent, not by this block.

## Test plan
Bench kernel stub: k_result = in_row1+in_row2 delayed LAT enabled cycles, cleared by k_rst.
- len=1, w={4,3,2,1}, in (5,6), out_ready=1 -> k_w1..4=1,2,3,4; single beat 11 at LAT cycles after fire; out_last=1; done pulse; busy falls.
- len=4, pairs (1,1),(2,2),(3,3),(4,4) gap-free -> beats 2,4,6,8 on consecutive cycles; out_last on 8 only.
- Same job, in_valid toggling 1/0 -> k_en high only on fire cycles; same 4 beats in order; no duplicates.
- Same job, out_ready low for 3 cycles on beat 2 -> out_data holds 4, k_en=0 and in_ready=0 during the stall; no beat lost.
- cfg_len=0 -> no out_valid, done one cycle after accept, cfg_ready stays 1.
- rst asserted in RUN after 2 fires of len=4 -> next cycle busy=0, out_valid=0, no done; a fresh len=2 job then yields exactly 2 beats.

Source files
------------

// File: rtl/kernal_pkg.sv
// Shared definitions for the 2x2 kernel sequencer: FSM state encoding and
// the result-width helper matching the kernel's accumulator output.
package kernal_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Kernel result width: two element-width products summed plus growth bits.
  function automatic int result_w(input int data_size);
    return 2 * data_size + 5;
  endfunction

endpackage

// File: rtl/valid_tag_pipe.sv
// Enable-gated tag shift register that tracks which kernel pipeline slots
// hold a real sample. The head bit lines up with the kernel's result port.
module valid_tag_pipe #(
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           push,
  output logic [LAT-1:0] tag,
  output logic           head,
  output logic           occupied
);

  // Shift a new tag in only when the kernel pipeline itself advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= '0;
    end else if (en) begin
      tag <= (tag << 1) | LAT'(push);
    end
  end

  assign head     = tag[LAT-1];
  assign occupied = |tag;

endmodule

// File: rtl/kernal_ctrl_2by2.sv
// Job sequencer for the 2x2 weight-stationary kernel. Latches a descriptor,
// streams input pairs into the kernel with a gated enable, and returns one
// result beat per accepted sample with backpressure and a last marker.
module kernal_ctrl_2by2
  import kernal_pkg::*;
#(
  parameter int dataSize = 8,
  parameter int LEN_W    = 8,
  parameter int LAT      = 2,
  localparam int RES_W   = result_w(dataSize)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [4*dataSize-1:0] cfg_w,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [dataSize-1:0]   in_row1,
  input  logic [dataSize-1:0]   in_row2,
  output logic                  k_en,
  output logic                  k_rst,
  output logic [dataSize-1:0]   k_in_row1,
  output logic [dataSize-1:0]   k_in_row2,
  output logic [dataSize-1:0]   k_w1,
  output logic [dataSize-1:0]   k_w2,
  output logic [dataSize-1:0]   k_w3,
  output logic [dataSize-1:0]   k_w4,
  input  logic [RES_W-1:0]      k_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RES_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   retired;
  logic               taken;
  logic               done_zero;
  logic               drain_done;
  logic               push;
  logic [LAT-1:0]     tag;
  logic               tag_head;
  logic               tag_occ;
  logic               cfg_fire;
  logic               in_fire;
  logic               out_fire;
  logic               stall;

  valid_tag_pipe #(.LAT(LAT)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .en       (k_en),
    .push     (push),
    .tag      (tag),
    .head     (tag_head),
    .occupied (tag_occ)
  );

  // A beat is pending while the head slot holds a sample not yet handed off.
  assign out_valid = tag_head & ~taken;
  assign stall     = out_valid & ~out_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = k_result;
  assign out_last  = out_valid & (retired == (len_q - LEN_W'(1)));

  assign cfg_ready = (state == IDLE);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign in_ready  = (state == RUN) & ~stall & (issued < len_q);
  assign in_fire   = in_valid & in_ready;

  assign busy  = (state != IDLE);
  assign k_rst = rst | (state == CLEAR);
  assign done  = drain_done | done_zero;

  // Next-state and kernel drive: enable only on real input or drain steps.
  always_comb begin
    state_nx   = state;
    k_en       = 1'b0;
    push       = 1'b0;
    k_in_row1  = '0;
    k_in_row2  = '0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_fire && (cfg_len != '0)) state_nx = CLEAR;
      end
      CLEAR: begin
        state_nx = RUN;
      end
      RUN: begin
        k_in_row1 = in_row1;
        k_in_row2 = in_row2;
        if (in_fire) begin
          k_en = 1'b1;
          push = 1'b1;
          if (issued == (len_q - LEN_W'(1))) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!tag_occ && !out_valid) begin
          drain_done = 1'b1;
          state_nx   = IDLE;
        end else if (!stall) begin
          k_en = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Job bookkeeping: length, issue/retire counters, hand-off and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      issued    <= '0;
      retired   <= '0;
      taken     <= 1'b0;
      done_zero <= 1'b0;
    end else begin
      done_zero <= cfg_fire && (cfg_len == '0);
      if (cfg_fire) begin
        len_q   <= cfg_len;
        issued  <= '0;
        retired <= '0;
      end else begin
        if (in_fire)  issued  <= issued + LEN_W'(1);
        if (out_fire) retired <= retired + LEN_W'(1);
      end
      if (k_en)          taken <= 1'b0;
      else if (out_fire) taken <= 1'b1;
    end
  end

  // Weights are held from descriptor accept until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_w1 <= '0;
      k_w2 <= '0;
      k_w3 <= '0;
      k_w4 <= '0;
    end else if (cfg_fire) begin
      k_w1 <= cfg_w[0*dataSize +: dataSize];
      k_w2 <= cfg_w[1*dataSize +: dataSize];
      k_w3 <= cfg_w[2*dataSize +: dataSize];
      k_w4 <= cfg_w[3*dataSize +: dataSize];
    end
  end

endmodule
